// File: rtl/ccd_cds_sampler.sv
// ---------------------------------------------------------------------------
// ccd_cds_sampler
//
// Purpose:
//   Sits after the CCD clock-phase generator. It watches the phi_r and phi_l2
//   phases, strobes an external ADC once at the reset level and once at the
//   signal level of every pixel, and forms the correlated-double-sampling
//   difference (reset - signal, floored at 0). Each result is tagged with an
//   8-bit pixel index and queued in a small FIFO. The management core reads
//   the FIFO and a few control/status registers over Wishbone.
//
// Ports:
//   wb_clk_i        single system clock
//   wb_rst_i        synchronous reset, active low (0 = reset)
//   wbs_stb_i       Wishbone strobe
//   wbs_cyc_i       Wishbone cycle
//   wbs_we_i        Wishbone write enable
//   wbs_sel_i       byte selects (ignored, full-word access only)
//   wbs_dat_i       Wishbone write data
//   wbs_adr_i       Wishbone address
//   wbs_ack_o       one-cycle acknowledge, the cycle after a decoded access
//   wbs_dat_o       read data, valid with ack and 0 otherwise
//   i_phi_p         parallel-transfer phase (asynchronous)
//   i_phi_l2        horizontal phase 2 (asynchronous)
//   i_phi_r         reset-gate phase (asynchronous)
//   i_adc_data      ADC output, valid on the cycle after the strobe
//   o_adc_strobe    one-cycle ADC convert pulse
//   o_fifo_nempty   FIFO holds at least one result
//
// Register map (offsets from BASE_ADDR):
//   +0 CTRL   W: bit0 enable, bit1 = 1 clears overflow   R: {31'b0, enable}
//   +4 STATUS R: [3:0] level, [4] empty, [5] full, [6] overflow,
//                [15:8] pixel counter
//   +8 DATA   R: pops the head entry (0 when empty, no state change)
// ---------------------------------------------------------------------------
module ccd_cds_sampler #(
    parameter int          ADC_W      = 12,
    parameter int          FIFO_DEPTH = 8,
    parameter int          SETTLE_CYC = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0020
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_dat_i,
    input  logic [31:0]       wbs_adr_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic              i_phi_p,
    input  logic              i_phi_l2,
    input  logic              i_phi_r,
    input  logic [ADC_W-1:0]  i_adc_data,
    output logic              o_adc_strobe,
    output logic              o_fifo_nempty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYC - 1);

    typedef enum logic [3:0] {
        IDLE,
        WAIT_R,
        SET_R,
        STB_R,
        CAP_R,
        WAIT_S,
        SET_S,
        STB_S,
        CAP_S,
        PUSH
    } state_t;

    state_t state_q, state_d;

    logic [2:0]       phiSync1_q, phiSync2_q, phiPrev_q;
    logic             phiRFall_q, phiL2Fall_q, phiPRise_q;
    logic [7:0]       settleCnt_q;
    logic [ADC_W-1:0] rstLvl_q, sigLvl_q;
    logic [7:0]       pixelCnt_q;
    logic             enable_q, overflow_q;
    logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
    logic [LVL_W-1:0] level_q, level_d;
    logic [31:0]      fifoMem [FIFO_DEPTH];
    logic             ack_q;
    logic [31:0]      dat_q;

    logic             loadCnt, capR, capS, pushReq;
    logic [ADC_W:0]   diffWide;
    logic [ADC_W-1:0] diff;
    logic [31:0]      pushEntry, statusWord, readData;
    logic             selCtrl, selStatus, selData, access;
    logic             fifoEmpty, fifoFull, popReq, pushOk, ovfSet;
    logic             unusedBits;

    assign unusedBits = ^{wbs_sel_i, wbs_dat_i[31:2]};

    // Two-flop synchronizer on the three phases, followed by a registered
    // edge detector. phiPrev_q holds the previous synchronized value so each
    // detected edge is a single-cycle pulse. Bit order is {p, l2, r}.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            phiSync1_q  <= '0;
            phiSync2_q  <= '0;
            phiPrev_q   <= '0;
            phiRFall_q  <= 1'b0;
            phiL2Fall_q <= 1'b0;
            phiPRise_q  <= 1'b0;
        end else begin
            phiSync1_q  <= {i_phi_p, i_phi_l2, i_phi_r};
            phiSync2_q  <= phiSync1_q;
            phiPrev_q   <= phiSync2_q;
            phiRFall_q  <= phiPrev_q[0] & ~phiSync2_q[0];
            phiL2Fall_q <= phiPrev_q[1] & ~phiSync2_q[1];
            phiPRise_q  <= ~phiPrev_q[2] & phiSync2_q[2];
        end
    end

    // Pixel sequencer. Phase edges only matter in the two WAIT states, so
    // edges arriving while settling are dropped rather than re-triggering.
    // Clearing enable aborts any partial pixel; a pixel already in PUSH has
    // both levels and is still written.
    always_comb begin
        state_d = state_q;
        loadCnt = 1'b0;
        capR    = 1'b0;
        capS    = 1'b0;
        pushReq = 1'b0;
        case (state_q)
            IDLE:   if (enable_q) state_d = WAIT_R;
            WAIT_R: if (phiRFall_q) begin
                        state_d = SET_R;
                        loadCnt = 1'b1;
                    end
            SET_R:  if (settleCnt_q == 8'd0) state_d = STB_R;
            STB_R:  state_d = CAP_R;
            CAP_R:  begin
                        capR    = 1'b1;
                        state_d = WAIT_S;
                    end
            WAIT_S: if (phiL2Fall_q) begin
                        state_d = SET_S;
                        loadCnt = 1'b1;
                    end
            SET_S:  if (settleCnt_q == 8'd0) state_d = STB_S;
            STB_S:  state_d = CAP_S;
            CAP_S:  begin
                        capS    = 1'b1;
                        state_d = PUSH;
                    end
            PUSH:   begin
                        pushReq = 1'b1;
                        state_d = WAIT_R;
                    end
            default: state_d = IDLE;
        endcase
        if (!enable_q && state_q != IDLE) begin
            state_d = IDLE;
            loadCnt = 1'b0;
            capR    = 1'b0;
            capS    = 1'b0;
        end
    end

    // State register, settle countdown and the two captured ADC levels.
    // Levels are wiped in IDLE so an aborted pixel leaves nothing behind.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state_q     <= IDLE;
            settleCnt_q <= '0;
            rstLvl_q    <= '0;
            sigLvl_q    <= '0;
        end else begin
            state_q <= state_d;
            if (loadCnt) begin
                settleCnt_q <= SETTLE_LOAD;
            end else if ((state_q == SET_R || state_q == SET_S) && settleCnt_q != 8'd0) begin
                settleCnt_q <= settleCnt_q - 8'd1;
            end
            if (state_q == IDLE) begin
                rstLvl_q <= '0;
                sigLvl_q <= '0;
            end else begin
                if (capR) rstLvl_q <= i_adc_data;
                if (capS) sigLvl_q <= i_adc_data;
            end
        end
    end

    assign o_adc_strobe = (state_q == STB_R) || (state_q == STB_S);

    // CDS difference one bit wider than the samples; the borrow bit marks a
    // negative result, which is floored to zero.
    always_comb begin
        diffWide  = {1'b0, rstLvl_q} - {1'b0, sigLvl_q};
        diff      = diffWide[ADC_W] ? '0 : diffWide[ADC_W-1:0];
        pushEntry = '0;
        pushEntry[ADC_W-1:0] = diff;
        pushEntry[23:16]     = pixelCnt_q;
    end

    // Bus decode and FIFO handshake. A pop and a push in the same cycle both
    // proceed, so a full FIFO still accepts a push if it is being read.
    always_comb begin
        selCtrl   = (wbs_adr_i == BASE_ADDR);
        selStatus = (wbs_adr_i == BASE_ADDR + 32'd4);
        selData   = (wbs_adr_i == BASE_ADDR + 32'd8);
        access    = wbs_stb_i & wbs_cyc_i & ~ack_q & (selCtrl | selStatus | selData);
        fifoEmpty = (level_q == '0);
        fifoFull  = (level_q == LVL_W'(FIFO_DEPTH));
        popReq    = access & ~wbs_we_i & selData & ~fifoEmpty;
        pushOk    = pushReq & (~fifoFull | popReq);
        ovfSet    = pushReq & fifoFull & ~popReq;
        level_d   = level_q;
        case ({pushOk, popReq})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Register read multiplexer; CTRL bit1 is a write-only action bit.
    always_comb begin
        statusWord       = '0;
        statusWord[3:0]  = 4'(level_q);
        statusWord[4]    = fifoEmpty;
        statusWord[5]    = fifoFull;
        statusWord[6]    = overflow_q;
        statusWord[15:8] = pixelCnt_q;
        readData = '0;
        if (selCtrl) begin
            readData[0] = enable_q;
        end else if (selStatus) begin
            readData = statusWord;
        end else if (selData && !fifoEmpty) begin
            readData = fifoMem[rdPtr_q];
        end
    end

    // FIFO pointers, sticky overflow, pixel counter, enable and the bus
    // response. A phi_p rise beats a same-cycle increment; the entry pushed
    // in that cycle already carries the pre-clear index.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            pixelCnt_q <= '0;
            enable_q   <= 1'b0;
            ack_q      <= 1'b0;
            dat_q      <= '0;
        end else begin
            level_q <= level_d;
            if (pushOk) wrPtr_q <= wrPtr_q + PTR_W'(1);
            if (popReq) rdPtr_q <= rdPtr_q + PTR_W'(1);
            if (phiPRise_q) begin
                pixelCnt_q <= '0;
            end else if (pushReq) begin
                pixelCnt_q <= pixelCnt_q + 8'd1;
            end
            if (access && wbs_we_i && selCtrl) enable_q <= wbs_dat_i[0];
            if (ovfSet) begin
                overflow_q <= 1'b1;
            end else if (access && wbs_we_i && selCtrl && wbs_dat_i[1]) begin
                overflow_q <= 1'b0;
            end
            ack_q <= access;
            dat_q <= (access && !wbs_we_i) ? readData : 32'd0;
        end
    end

    // Result storage; only slots between the pointers are ever read.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i && pushOk) begin
            fifoMem[wrPtr_q] <= pushEntry;
        end
    end

    assign wbs_ack_o     = ack_q;
    assign wbs_dat_o     = dat_q;
    assign o_fifo_nempty = ~fifoEmpty;

endmodule

// File: tb/tb_ccd_cds_sampler.sv
// ---------------------------------------------------------------------------
// tb_ccd_cds_sampler
//
// Purpose:
//   Self-checking bench for ccd_cds_sampler. Drives phase sequences and an
//   ADC level per pixel, reads results over Wishbone and compares them with
//   a transaction-level model (a queue of expected entries, a pixel index
//   and an overflow flag) plus a table of hand-computed CDS results.
// ---------------------------------------------------------------------------
module tb_ccd_cds_sampler;

    localparam logic [31:0] CTRL_A   = 32'h3000_0020;
    localparam logic [31:0] STATUS_A = 32'h3000_0024;
    localparam logic [31:0] DATA_A   = 32'h3000_0028;

    logic        clk = 1'b0;
    logic        wbRst;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] datIn, adr;
    logic        ack;
    logic [31:0] datOut;
    logic        phiP, phiL2, phiR;
    logic [11:0] adcData;
    logic        strobe, nempty;

    int checks = 0;
    int errors = 0;

    logic [31:0] modelQ [$];
    int          modelCnt = 0;
    bit          modelOvf = 1'b0;

    typedef struct {
        logic [11:0] rstLvl;
        logic [11:0] sigLvl;
        logic [31:0] expData;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    ccd_cds_sampler dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (wbRst),
        .wbs_stb_i     (stb),
        .wbs_cyc_i     (cyc),
        .wbs_we_i      (we),
        .wbs_sel_i     (sel),
        .wbs_dat_i     (datIn),
        .wbs_adr_i     (adr),
        .wbs_ack_o     (ack),
        .wbs_dat_o     (datOut),
        .i_phi_p       (phiP),
        .i_phi_l2      (phiL2),
        .i_phi_r       (phiR),
        .i_adc_data    (adcData),
        .o_adc_strobe  (strobe),
        .o_fifo_nempty (nempty)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] modelEntry(input int r, input int s, input int idx);
        int d;
        d = r - s;
        if (d < 0) d = 0;
        return (32'(idx % 256) << 16) | 32'(d);
    endfunction

    function automatic logic [31:0] modelStatus();
        int lvl;
        lvl = modelQ.size();
        return (32'(modelCnt % 256) << 8) | (32'(modelOvf) << 6) |
               (32'(lvl == 8) << 5) | (32'(lvl == 0) << 4) | 32'(lvl);
    endfunction

    task automatic wbAccess(input logic [31:0] a, input logic w, input logic [31:0] wd,
                            output logic [31:0] rd, output bit acked);
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; datIn = wd;
        acked = 1'b0;
        rd = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ack) begin
                acked = 1'b1;
                rd = datOut;
                break;
            end
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic wbWrite(input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] rd;
        bit acked;
        wbAccess(a, 1'b1, wd, rd, acked);
        checkOutput("write ack", 32'(acked), 32'd1);
    endtask

    task automatic wbRead(input logic [31:0] a, output logic [31:0] rd);
        bit acked;
        wbAccess(a, 1'b0, 32'd0, rd, acked);
        checkOutput("read ack", 32'(acked), 32'd1);
    endtask

    task automatic checkStatus(input string name);
        logic [31:0] rd;
        wbRead(STATUS_A, rd);
        checkOutput(name, rd, modelStatus());
    endtask

    task automatic readData(input string name, output logic [31:0] rd);
        logic [31:0] exp;
        exp = (modelQ.size() > 0) ? modelQ.pop_front() : 32'd0;
        wbRead(DATA_A, rd);
        checkOutput(name, rd, exp);
    endtask

    // Waits for the ADC strobe after a phase fall; optionally raises phi_p so
    // its detected edge coincides with the PUSH cycle.
    task automatic waitStrobe(input string name, input bit coin);
        int cycles;
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
            if (coin && cycles == 7) phiP = 1'b1;
        end while (!strobe && cycles < 40);
        checkOutput(name, 32'(cycles), 32'd8);
    endtask

    // One full pixel: reset level, phi_r fall, signal level, phi_l2 fall.
    task automatic applyStimulus(input logic [11:0] r, input logic [11:0] s, input bit coin);
        adcData = r;
        @(negedge clk);
        phiR = 1'b0;
        waitStrobe("strobe latency R", 1'b0);
        @(negedge clk);
        checkOutput("strobe width R", 32'(strobe), 32'd0);
        @(negedge clk);
        adcData = s;
        phiR = 1'b1;
        repeat (2) @(negedge clk);
        phiL2 = 1'b0;
        waitStrobe("strobe latency S", coin);
        @(negedge clk);
        checkOutput("strobe width S", 32'(strobe), 32'd0);
        repeat (2) @(negedge clk);
        phiL2 = 1'b1;
        phiP = 1'b0;
        if (modelQ.size() < 8) modelQ.push_back(modelEntry(int'(r), int'(s), modelCnt));
        else modelOvf = 1'b1;
        modelCnt = coin ? 0 : (modelCnt + 1) % 256;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulsePhiP();
        @(negedge clk);
        phiP = 1'b1;
        repeat (5) @(negedge clk);
        phiP = 1'b0;
        repeat (5) @(negedge clk);
        modelCnt = 0;
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] got [7];
        bit acked;
        int strobes;

        vecs[0] = '{12'h800, 12'h300, 32'h0000_0500};
        vecs[1] = '{12'h100, 12'h200, 32'h0001_0000};
        vecs[2] = '{12'hFFF, 12'h000, 32'h0002_0FFF};
        vecs[3] = '{12'h555, 12'h555, 32'h0003_0000};
        vecs[4] = '{12'h000, 12'hFFF, 32'h0004_0000};
        vecs[5] = '{12'h801, 12'h800, 32'h0005_0001};

        wbRst = 1'b0;
        stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'hF; datIn = '0; adr = '0;
        phiP = 1'b0; phiL2 = 1'b1; phiR = 1'b1; adcData = '0;

        // Reset held with phases toggling.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            phiP = ~phiP; phiL2 = ~phiL2; phiR = ~phiR;
            checkOutput("reset strobe", 32'(strobe), 32'd0);
            checkOutput("reset ack", 32'(ack), 32'd0);
            checkOutput("reset dat", datOut, 32'd0);
            checkOutput("reset nempty", 32'(nempty), 32'd0);
        end
        @(negedge clk);
        phiP = 1'b0; phiL2 = 1'b1; phiR = 1'b1;
        wbRst = 1'b1;
        repeat (4) @(negedge clk);
        wbRead(STATUS_A, rd);
        checkOutput("reset status", rd, 32'h0000_0010);

        wbWrite(CTRL_A, 32'd1);
        wbRead(CTRL_A, rd);
        checkOutput("ctrl readback", rd, 32'd1);

        // Table-driven CDS arithmetic, one pixel then one read each.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].rstLvl, vecs[i].sigLvl, 1'b0);
            checkOutput("nempty after push", 32'(nempty), 32'd1);
            void'(modelQ.pop_front());
            wbRead(DATA_A, rd);
            checkOutput("cds table", rd, vecs[i].expData);
            checkStatus("status after pop");
        end

        // Overflow: ten pixels with no reads.
        pulsePhiP();
        for (int i = 0; i < 10; i++) applyStimulus(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)), 1'b0);
        wbRead(STATUS_A, rd);
        checkOutput("overflow status", rd, 32'h0000_0A68);
        for (int i = 0; i < 8; i++) begin
            readData("overflow data", rd);
            checkOutput("overflow index", 32'(rd[23:16]), 32'(i));
        end
        wbWrite(CTRL_A, 32'd3);
        modelOvf = 1'b0;
        checkStatus("overflow cleared");

        // Line clear, then a clear coincident with a push.
        pulsePhiP();
        for (int i = 0; i < 5; i++) applyStimulus(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)), 1'b0);
        pulsePhiP();
        applyStimulus(12'h400, 12'h100, 1'b0);
        for (int i = 0; i < 6; i++) readData("line clear data", rd);
        checkOutput("line clear index", 32'(rd[23:16]), 32'd0);
        pulsePhiP();
        for (int i = 0; i < 5; i++) applyStimulus(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)), 1'b0);
        applyStimulus(12'h300, 12'h100, 1'b1);
        applyStimulus(12'h200, 12'h100, 1'b0);
        for (int i = 0; i < 7; i++) readData("coincident data", got[i]);
        checkOutput("coincident index", 32'(got[5][23:16]), 32'd5);
        checkOutput("after clear index", 32'(got[6][23:16]), 32'd0);
        checkStatus("status after coincident");

        // Disable during the signal-level settle.
        adcData = 12'h700;
        @(negedge clk);
        phiR = 1'b0;
        waitStrobe("strobe latency R", 1'b0);
        repeat (2) @(negedge clk);
        phiR = 1'b1;
        repeat (2) @(negedge clk);
        phiL2 = 1'b0;
        repeat (4) @(negedge clk);
        wbWrite(CTRL_A, 32'd0);
        strobes = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (strobe) strobes++;
        end
        phiL2 = 1'b1;
        checkOutput("disable no strobe", 32'(strobes), 32'd0);
        checkStatus("disable no push");
        repeat (3) @(negedge clk);
        phiR = 1'b0;
        strobes = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (strobe) strobes++;
        end
        phiR = 1'b1;
        checkOutput("idle ignores phases", 32'(strobes), 32'd0);
        repeat (3) @(negedge clk);
        wbWrite(CTRL_A, 32'd1);
        applyStimulus(12'h900, 12'h100, 1'b0);
        readData("after re-enable", rd);

        // Bus corner cases.
        wbAccess(DATA_A, 1'b0, 32'd0, rd, acked);
        checkOutput("empty read ack", 32'(acked), 32'd1);
        checkOutput("empty read data", rd, 32'd0);
        @(negedge clk);
        checkOutput("ack single cycle", 32'(ack), 32'd0);
        wbAccess(32'h3000_0030, 1'b0, 32'd0, rd, acked);
        checkOutput("unmatched ack", 32'(acked), 32'd0);
        checkOutput("unmatched dat", datOut, 32'd0);
        checkStatus("status after bus cases");

        // Randomized pixels, reads and line clears against the model.
        for (int i = 0; i < 24; i++) begin
            applyStimulus(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
                          $urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0: readData("random data", rd);
                1: checkStatus("random status");
                2: pulsePhiP();
                default: ;
            endcase
        end
        checkStatus("random final status");
        while (modelQ.size() > 0) readData("random drain", rd);
        readData("drained empty read", rd);
        wbWrite(CTRL_A, 32'd3);
        modelOvf = 1'b0;
        checkStatus("final status");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ccd_cds_sampler.md
Name: ccd_cds_sampler

Overview:
- Downstream companion of the CCD clock-phase generator.
- Consumes the generated phi_p / phi_l2 / phi_r phases and strobes an external ADC at the reset and signal levels of each pixel.
- Forms the correlated-double-sampling difference (reset − signal) and buffers results in a small FIFO.
- The management core reads the FIFO over Wishbone at the address window directly after the generator's registers.

Parameters:
- ADC_W, 12, ADC sample width in bits.
- FIFO_DEPTH, 8, result FIFO entries (power of 2).
- SETTLE_CYC, 4, wb_clk_i cycles between the qualifying phase edge and the ADC strobe (range 1..255).
- BASE_ADDR, 32'h3000_0020, Wishbone base; registers at +0 CTRL, +4 STATUS, +8 DATA.

Ports:
- wb_clk_i  in  1  single system clock
- wb_rst_i  in  1  synchronous, active-low reset (0 = reset)
- wbs_stb_i  in  1  Wishbone strobe
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_we_i  in  1  Wishbone write enable
- wbs_sel_i  in  4  byte selects (ignored; full-word access only)
- wbs_dat_i  in  32  write data
- wbs_adr_i  in  32  address
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- i_phi_p  in  1  parallel-transfer phase (asynchronous)
- i_phi_l2  in  1  horizontal phase 2 (asynchronous)
- i_phi_r  in  1  reset-gate phase (asynchronous)
- i_adc_data  in  ADC_W  ADC parallel output, valid on the cycle after the strobe
- o_adc_strobe  out  1  one-cycle ADC convert pulse
- o_fifo_nempty  out  1  FIFO holds ≥1 result (interrupt-capable)

Behaviour:
- Reset (wb_rst_i=0 at a clock edge) clears:
  - all outputs to 0
  - FSM to IDLE
  - FIFO empty; overflow flag, pixel counter and enable to 0
- Phase inputs pass through a 2-flop synchronizer, then a registered edge detector.
  - Edge-to-FSM latency: 3 cycles.
- FSM states and transitions:
  - IDLE: leave when enable=1 → WAIT_R.
  - WAIT_R: on phi_r falling edge → SET_R (counter loaded with SETTLE_CYC−1).
  - SET_R: count down to 0 → STB_R.
  - STB_R: o_adc_strobe=1 for exactly one cycle → CAP_R.
  - CAP_R: latch i_adc_data as rst_lvl → WAIT_S.
  - WAIT_S: on phi_l2 falling edge → SET_S.
  - SET_S: count down → STB_S (strobe).
  - STB_S → CAP_S: latch sig_lvl → PUSH.
  - PUSH: write one entry → WAIT_R.
- CDS arithmetic:
  - diff = rst_lvl − sig_lvl, computed at ADC_W+1 bits.
  - A negative result saturates to 0; the result is ADC_W bits.
- FIFO entry:
  - bits [ADC_W-1:0] = diff
  - bits [23:16] = pixel index (8-bit counter, wraps 255→0)
  - all other bits 0
- Pixel counter:
  - increments on every PUSH attempt.
  - cleared by a phi_p rising edge.
  - If the clear and the increment fall in the same cycle, the clear wins and the entry carries the pre-clear index.
- FIFO full at PUSH: entry dropped, overflow sticky set, counter still increments.
- enable cleared mid-pixel: next cycle FSM → IDLE; partial levels discarded; FIFO contents retained.
- phi edges outside WAIT_R/WAIT_S are ignored (no re-trigger during settle).
- Wishbone slave:
  - Decode wbs_stb_i & wbs_cyc_i & (wbs_adr_i within BASE_ADDR..+8).
  - wbs_ack_o is asserted the cycle after decode, for one cycle only; it is never asserted for unmatched addresses.
  - wbs_dat_o is valid with ack and is 0 otherwise.
- Registers:
  - CTRL write: bit0 = enable; bit1 = 1 clears overflow. CTRL read: {30'b0, 1'b0, enable}.
  - STATUS read: [3:0] level (0..FIFO_DEPTH), [4] empty, [5] full, [6] overflow, [15:8] pixel counter.
  - DATA read: pops the head entry; on empty returns 0 with no state change. Writes to STATUS/DATA are ignored.
- Simultaneous push and pop:
  - Both occur; level unchanged, including when full.
  - If empty, the pop returns 0 and the push lands.

Test Plan:
- Reset: hold wb_rst_i=0 for 3 cycles with phases toggling → all outputs 0, STATUS=0x0000_0010, no strobe.
- Single pixel: enable=1, SETTLE_CYC=4, phi_r fall → strobe exactly 8 cycles later; i_adc_data=0x800 → phi_l2 fall, i_adc_data=0x300 → DATA read = 0x0000_0500, level returns to 0.
- Saturation: rst_lvl=0x100, sig_lvl=0x200 → DATA[11:0]=0x000.
- Overflow: 10 pixels with no reads → level=8, full=1, overflow=1. Reads return indices 0..7; CTRL write 0x3 clears overflow.
- Line clear: 5 pixels, then phi_p rise → next entry index 0. Coincident clear and push: that entry carries index 5, the following entry index 0.
- Disable mid-pixel and bus cases: enable cleared during SET_S → no push, FSM idle. DATA read on empty → 0, ack 1 cycle. Access to 0x3000_0030 → no ack.
